// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB-first, one bit per clock.
// Ports: clk_in/rst_in (sync, active-high), start_in + a_in/b_in operands,
//        busy_out, done_out (1-cycle pulse), diff_out/borrow_out (held results).
// Optional macro SERIAL_SUB_OVERFLOW_EN adds overflow_out (signed overflow flag).
// Latency: start accepted at edge 0 -> done_out high after edge WIDTH; next start at WIDTH+2.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow_out
`endif
);

  // Counter must be able to hold WIDTH itself so it never wraps.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-2:0]   res_q;      // bits already produced, newest at the top
  logic               br_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   diff_q;
  logic               borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic               ovf_q;
`endif

  logic               last_bit;
  logic               bit_d;
  logic               br_nxt;
  logic [WIDTH-1:0]   acc;

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // One full-subtractor stage on the current LSBs.
  assign bit_d  = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  // On the final bit this is the complete difference; otherwise its upper
  // WIDTH-1 bits are the shifted partial result.
  assign acc    = {bit_d, res_q};

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_in) state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_out = 1'b0;
    done_out = 1'b0;
    case (state_q)
      S_SHIFT: busy_out = 1'b1;
      S_DONE:  done_out = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            a_q   <= a_in;
            b_q   <= b_in;
            res_q <= '0;
            br_q  <= 1'b0;
            cnt_q <= '0;
          end
        end
        S_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= acc[WIDTH-1:1];
          br_q  <= br_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          // Visible results change only once the whole word is known.
          if (last_bit) begin
            diff_q   <= acc;
            borrow_q <= br_nxt;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // On the last bit a_q[0]/b_q[0] are the original sign bits.
            ovf_q    <= (a_q[0] ^ b_q[0]) & (bit_d ^ a_q[0]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign diff_out   = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign overflow_out = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits; legal range 2..32.
REQ-002 clk_in  input  1  Sole clock; all state updates on its rising edge.
REQ-003 rst_in  input  1  Reset; synchronous, active-high.
REQ-004 start_in  input  1  Request to begin a subtraction; sampled only in IDLE.
REQ-005 a_in  input  WIDTH  Minuend; captured on the accepted start edge.
REQ-006 b_in  input  WIDTH  Subtrahend; captured on the accepted start edge.
REQ-007 busy_out  output  1  High while the block is in SHIFT.
REQ-008 done_out  output  1  One-cycle pulse; result valid.
REQ-009 diff_out  output  WIDTH  a minus b, modulo 2^WIDTH; held until the next accepted start.
REQ-010 borrow_out  output  1  Final borrow (1 = a < b unsigned); held with diff_out.

Function
REQ-011 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 IDLE -> SHIFT on an edge with start_in=1; capture a_in/b_in into shift registers; clear the borrow flop and the bit counter; IDLE otherwise.
REQ-013 Each SHIFT edge SHALL process one bit LSB-first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-014 Each SHIFT edge SHALL shift d into the MSB of the result register, shift both operand registers right by one, and increment the counter.
REQ-015 SHIFT -> DONE on the WIDTH-th SHIFT edge; the counter SHALL count exactly WIDTH bits with no wrap.
REQ-016 diff_out and borrow_out SHALL update only on the SHIFT -> DONE edge, not bit by bit.
REQ-017 done_out SHALL be high for exactly the single cycle spent in DONE; DONE -> IDLE unconditionally.
REQ-018 Latency: if start is accepted at edge 0, done_out is high in the cycle following edge WIDTH; the next start is accepted no earlier than edge WIDTH+2.
REQ-019 start_in in SHIFT or DONE SHALL be ignored; a_in/b_in changes after capture SHALL not affect the result.
REQ-020 start_in held high continuously SHALL start a new operation at each return to IDLE, with no lost or duplicated done pulses.

Reset
REQ-021 rst_in=1 at an edge SHALL force IDLE and set busy_out=0, done_out=0, diff_out=0, borrow_out=0; clear the counter, borrow flop and operand registers.
REQ-022 Reset SHALL take priority over start_in and over any in-progress operation; an aborted operation SHALL produce no done pulse.

Configuration
REQ-023 Macro SERIAL_SUB_OVERFLOW_EN, when defined, SHALL add output overflow_out (1 bit): the signed two's-complement overflow flag, a[MSB] != b[MSB] and diff[MSB] != a[MSB], updated with diff_out and reset to 0.
REQ-024 Without SERIAL_SUB_OVERFLOW_EN, the port SHALL be absent and the remaining behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-025 a=0x05, b=0x03, start pulse -> done after 8 cycles; diff=0x02, borrow=0, overflow=0.
REQ-026 a=0x03, b=0x05 -> diff=0xFE, borrow=1, overflow=0.
REQ-027 a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1 (macro defined); a=0xFF, b=0xFF -> diff=0x00, borrow=0.
REQ-028 start plus new a/b pulsed at SHIFT bit 3 -> ignored; the first result is unchanged; exactly one done pulse.
REQ-029 rst_in at SHIFT bit 4 -> next cycle: IDLE, all outputs 0, no done pulse; a fresh start then completes correctly.
REQ-030 start_in held high for 30 cycles with a=0x10, b=0x20 -> done pulses every 10 cycles; diff=0xF0, borrow=1 each time.
